// File: rtl/tcore_param_pkg.sv
// Shared branch-predictor types and default sizes.
// Optional feature macro: TCORE_BP_PERF_EN adds a BTB-miss flag to each
// queue entry so the top level can count taken branches lost to tag misses.
package tcore_param;

    localparam int BP_PHT_ENTRIES = 256;
    localparam int BP_BTB_ENTRIES = 128;
    localparam int BP_GHR_BITS    = 10;
    localparam int BP_TAG_BITS    = 12;
    localparam int BP_INFLIGHT    = 4;

    localparam int BP_PHT_IW = $clog2(BP_PHT_ENTRIES);
    localparam int BP_BTB_IW = $clog2(BP_BTB_ENTRIES);

    // One in-flight prediction: where it read the tables, what it guessed,
    // and the speculative history it saw, so a mispredict can rewind to it.
    // Field widths follow the package defaults; the predictor is expected to
    // be instantiated with sizes no wider than these.
    typedef struct packed {
        logic [BP_PHT_IW-1:0]   idx;
        logic [BP_BTB_IW-1:0]   bidx;
        logic [BP_TAG_BITS-1:0] tag;
        logic                   taken;
        logic [31:0]            target;
        logic [BP_GHR_BITS-1:0] ghr;
`ifdef TCORE_BP_PERF_EN
        logic                   btbMiss;
`endif
    } bp_queue_entry_t;

    // Two-bit saturating counter step, clamped at 00 and 11.
    function automatic logic [1:0] satCounter(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        res = cnt;
        if (up) begin
            if (cnt != 2'b11) res = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_gshare_param_fifo.sv
// In-order queue of outstanding predictions. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
module bp_inflight_fifo
    import tcore_param::*;
#(
    parameter type entry_t = bp_queue_entry_t,
    parameter int  DEPTH   = BP_INFLIGHT
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t pushData_i,
    input  logic   pop_i,
    input  logic   flush_i,
    output logic   full_o,
    output logic   empty_o,
    output entry_t head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wrPtr_q, wrPtr_d;
    logic [PW:0] rdPtr_q, rdPtr_d;
    entry_t      mem_q [DEPTH];

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[PW] != rdPtr_q[PW]) && (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);
    assign head_o  = mem_q[rdPtr_q[PW-1:0]];

    // Pointer advance; a flush empties the queue and wins over push/pop.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (push_i && !full_o)  wrPtr_d = wrPtr_q + (PW+1)'(1);
            if (pop_i  && !empty_o) rdPtr_d = rdPtr_q + (PW+1)'(1);
        end
    end

    // Pointer registers; reset discards everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Entry storage needs no reset since the pointers gate every read.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o && !flush_i) mem_q[wrPtr_q[PW-1:0]] <= pushData_i;
    end

endmodule

// File: rtl/bp_gshare_param.sv
// Parametrised gshare direction predictor with tagged direct-mapped BTB,
// speculative global history and in-order checkpoint repair.
// Optional feature macro: TCORE_BP_PERF_EN adds 32-bit hit/miss/BTB-miss
// counters on extra output ports; prediction behaviour is unchanged.
module bp_gshare_param
    import tcore_param::*;
#(
    parameter int PHT_ENTRIES = BP_PHT_ENTRIES,
    parameter int BTB_ENTRIES = BP_BTB_ENTRIES,
    parameter int GHR_BITS    = BP_GHR_BITS,
    parameter int TAG_BITS    = BP_TAG_BITS,
    parameter int INFLIGHT    = BP_INFLIGHT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stall_i,
    input  logic                pred_valid_i,
    input  logic [31:0]         pred_pc_i,
    input  logic                pred_is_br_i,
    output logic                pred_ready_o,
    output logic                pred_taken_o,
    output logic [31:0]         pred_target_o,
    input  logic                res_valid_i,
    input  logic                res_taken_i,
    input  logic [31:0]         res_target_i,
    output logic                res_mispredict_o,
`ifdef TCORE_BP_PERF_EN
    output logic [31:0]         perf_br_hit_o,
    output logic [31:0]         perf_br_miss_o,
    output logic [31:0]         perf_btb_miss_o,
`endif
    output logic [GHR_BITS-1:0] ghr_spec_o,
    output logic [GHR_BITS-1:0] ghr_commit_o
);

    localparam int PHT_IW = $clog2(PHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);

    logic [1:0]          pht_q       [PHT_ENTRIES];
    logic                btbValid_q  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] btbTag_q    [BTB_ENTRIES];
    logic [31:0]         btbTarget_q [BTB_ENTRIES];

    logic [GHR_BITS-1:0] ghrSpec_q, ghrSpec_d;
    logic [GHR_BITS-1:0] ghrCommit_q, ghrCommit_d;

    logic [PHT_IW-1:0]   phtIdx;
    logic [BTB_IW-1:0]   btbIdx;
    logic [TAG_BITS-1:0] predTag;
    logic                btbHit;
    logic                enqFire;
    logic                resFire;

    bp_queue_entry_t     enqEntry;
    bp_queue_entry_t     headEntry;
    logic                fifoFull;
    logic                fifoEmpty;

    logic [PHT_IW-1:0]   headIdx;
    logic [BTB_IW-1:0]   headBidx;
    logic [TAG_BITS-1:0] headTag;
    logic [GHR_BITS-1:0] headGhr;
    logic [1:0]          phtNext;

    // Table lookup for the fetch PC, hashed with speculative history.
    assign phtIdx  = pred_pc_i[PHT_IW:1] ^ ghrSpec_q[PHT_IW-1:0];
    assign btbIdx  = pred_pc_i[BTB_IW:1];
    assign predTag = pred_pc_i[BTB_IW+TAG_BITS:BTB_IW+1];
    assign btbHit  = btbValid_q[btbIdx] && (btbTag_q[btbIdx] == predTag);

    assign pred_taken_o  = pred_valid_i & pred_is_br_i & pht_q[phtIdx][1] & btbHit;
    assign pred_target_o = pred_taken_o ? btbTarget_q[btbIdx] : (pred_pc_i + 32'd4);
    assign pred_ready_o  = !fifoFull;

    // Head fields narrowed back to this instance's table sizes.
    assign headIdx  = PHT_IW'(headEntry.idx);
    assign headBidx = BTB_IW'(headEntry.bidx);
    assign headTag  = TAG_BITS'(headEntry.tag);
    assign headGhr  = GHR_BITS'(headEntry.ghr);

    assign resFire          = res_valid_i && !fifoEmpty;
    assign res_mispredict_o = resFire &&
                              ((res_taken_i != headEntry.taken) ||
                               (res_taken_i && (res_target_i != headEntry.target)));
    assign enqFire          = pred_valid_i && pred_is_br_i && pred_ready_o &&
                              !stall_i && !res_mispredict_o;
    assign phtNext          = satCounter(pht_q[headIdx], res_taken_i);

    assign ghr_spec_o   = ghrSpec_q;
    assign ghr_commit_o = ghrCommit_q;

    // Checkpoint of everything needed to train and to rewind this prediction.
    always_comb begin
        enqEntry        = '0;
        enqEntry.idx    = BP_PHT_IW'(phtIdx);
        enqEntry.bidx   = BP_BTB_IW'(btbIdx);
        enqEntry.tag    = BP_TAG_BITS'(predTag);
        enqEntry.taken  = pred_taken_o;
        enqEntry.target = pred_target_o;
        enqEntry.ghr    = BP_GHR_BITS'(ghrSpec_q);
`ifdef TCORE_BP_PERF_EN
        enqEntry.btbMiss = pht_q[phtIdx][1] && !btbHit;
`endif
    end

    bp_inflight_fifo #(
        .entry_t (bp_queue_entry_t),
        .DEPTH   (INFLIGHT)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (enqFire),
        .pushData_i (enqEntry),
        .pop_i      (resFire),
        .flush_i    (res_mispredict_o),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .head_o     (headEntry)
    );

    // History next-state: a mispredict rewinds to the head checkpoint plus the real outcome.
    always_comb begin
        ghrSpec_d   = ghrSpec_q;
        ghrCommit_d = ghrCommit_q;
        if (res_mispredict_o) begin
            ghrSpec_d = {headGhr[GHR_BITS-2:0], res_taken_i};
        end else if (enqFire) begin
            ghrSpec_d = {ghrSpec_q[GHR_BITS-2:0], pred_taken_o};
        end
        if (resFire) begin
            ghrCommit_d = {ghrCommit_q[GHR_BITS-2:0], res_taken_i};
        end
    end

    // History registers.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            ghrSpec_q   <= '0;
            ghrCommit_q <= '0;
        end else begin
            ghrSpec_q   <= ghrSpec_d;
            ghrCommit_q <= ghrCommit_d;
        end
    end

    // Direction counters train on every resolve and restart weakly not-taken.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= 2'b01;
        end else if (resFire) begin
            pht_q[headIdx] <= phtNext;
        end
    end

    // BTB valid bits: taken resolves allocate, not-taken only evicts its own tag.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btbValid_q[i] <= 1'b0;
        end else if (resFire) begin
            if (res_taken_i) begin
                btbValid_q[headBidx] <= 1'b1;
            end else if (btbTag_q[headBidx] == headTag) begin
                btbValid_q[headBidx] <= 1'b0;
            end
        end
    end

    // BTB payload needs no reset because the valid bit qualifies it.
    always_ff @(posedge clk_i) begin
        if (resFire && res_taken_i) begin
            btbTag_q[headBidx]    <= headTag;
            btbTarget_q[headBidx] <= res_target_i;
        end
    end

`ifdef TCORE_BP_PERF_EN
    logic [31:0] perfBrHit_q, perfBrMiss_q, perfBtbMiss_q;

    assign perf_br_hit_o   = perfBrHit_q;
    assign perf_br_miss_o  = perfBrMiss_q;
    assign perf_btb_miss_o = perfBtbMiss_q;

    // Resolve statistics, wrapping naturally at 32 bits.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            perfBrHit_q   <= '0;
            perfBrMiss_q  <= '0;
            perfBtbMiss_q <= '0;
        end else if (resFire) begin
            if (res_mispredict_o) perfBrMiss_q <= perfBrMiss_q + 32'd1;
            else                  perfBrHit_q  <= perfBrHit_q + 32'd1;
            if (res_taken_i && headEntry.btbMiss) perfBtbMiss_q <= perfBtbMiss_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_gshare_param.sv
// Randomised and directed bench for bp_gshare_param against a behavioural
// model built from plain arrays and a queue of outstanding predictions.
module tb_bp_gshare_param;

    localparam int PHT      = 256;
    localparam int BTB      = 128;
    localparam int GHRB     = 10;
    localparam int TAGB     = 12;
    localparam int INFLIGHT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        predValid = 1'b0;
    logic [31:0] predPc = 32'h0;
    logic        predIsBr = 1'b0;
    logic        predReady;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        resValid = 1'b0;
    logic        resTaken = 1'b0;
    logic [31:0] resTarget = 32'h0;
    logic        resMispredict;
    logic [GHRB-1:0] ghrSpec;
    logic [GHRB-1:0] ghrCommit;
`ifdef TCORE_BP_PERF_EN
    logic [31:0] perfHit, perfMiss, perfBtbMiss;
`endif

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        int          idx;
        int          bidx;
        int          tag;
        bit          taken;
        logic [31:0] target;
        int          ghr;
    } mEntry;

    int          mPht       [PHT];
    bit          mBtbValid  [BTB];
    int          mBtbTag    [BTB];
    logic [31:0] mBtbTarget [BTB];
    int          mGhrSpec;
    int          mGhrCommit;
    mEntry       mQ [$];

    logic [31:0] pcPool  [5] = '{32'h100, 32'h1F4, 32'h2A0, 32'h100100, 32'h300};
    logic [31:0] tgtPool [3] = '{32'h80, 32'h400, 32'h1000};

    bp_gshare_param dut (
        .clk_i            (clock),
        .rst_ni           (reset),
        .stall_i          (stall),
        .pred_valid_i     (predValid),
        .pred_pc_i        (predPc),
        .pred_is_br_i     (predIsBr),
        .pred_ready_o     (predReady),
        .pred_taken_o     (predTaken),
        .pred_target_o    (predTarget),
        .res_valid_i      (resValid),
        .res_taken_i      (resTaken),
        .res_target_i     (resTarget),
        .res_mispredict_o (resMispredict),
`ifdef TCORE_BP_PERF_EN
        .perf_br_hit_o    (perfHit),
        .perf_br_miss_o   (perfMiss),
        .perf_btb_miss_o  (perfBtbMiss),
`endif
        .ghr_spec_o       (ghrSpec),
        .ghr_commit_o     (ghrCommit)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < PHT; i++) mPht[i] = 1;
        for (int i = 0; i < BTB; i++) begin
            mBtbValid[i]  = 1'b0;
            mBtbTag[i]    = 0;
            mBtbTarget[i] = 32'h0;
        end
        mGhrSpec   = 0;
        mGhrCommit = 0;
        mQ.delete();
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic applyStimulus(input bit rst, input bit v, input bit br, input bit stl,
                                 input logic [31:0] pc, input bit rv, input bit rt,
                                 input logic [31:0] rtgt);
        int    idx, bidx, tag;
        bit    hit, expTaken, expReady, expMis, enq, pop;
        logic [31:0] expTarget;
        mEntry e, h;
        @(negedge clock);
        reset     = rst;
        predValid = v;
        predIsBr  = br;
        stall     = stl;
        predPc    = pc;
        resValid  = rv;
        resTaken  = rt;
        resTarget = rtgt;
        #1;
        idx       = int'(((pc >> 1) ^ 32'(mGhrSpec)) % PHT);
        bidx      = int'((pc >> 1) % BTB);
        tag       = int'((pc >> 8) % (1 << TAGB));
        hit       = mBtbValid[bidx] && (mBtbTag[bidx] == tag);
        expTaken  = v && br && (mPht[idx] >= 2) && hit;
        expTarget = expTaken ? mBtbTarget[bidx] : pc + 32'd4;
        expReady  = (mQ.size() < INFLIGHT);
        pop       = rv && (mQ.size() > 0);
        expMis    = pop && ((rt != mQ[0].taken) || (rt && (rtgt != mQ[0].target)));
        enq       = v && br && expReady && !stl && !expMis;

        checkOutput("predTaken",  {31'b0, predTaken},     {31'b0, expTaken});
        checkOutput("predTarget", predTarget,              expTarget);
        checkOutput("predReady",  {31'b0, predReady},     {31'b0, expReady});
        checkOutput("mispredict", {31'b0, resMispredict}, {31'b0, expMis});
        checkOutput("ghrSpec",    32'(ghrSpec),            32'(mGhrSpec));
        checkOutput("ghrCommit",  32'(ghrCommit),          32'(mGhrCommit));

        if (rst) begin
            modelReset();
        end else begin
            if (pop) begin
                h = mQ.pop_front();
                if (rt) begin
                    if (mPht[h.idx] < 3) mPht[h.idx]++;
                    mBtbValid[h.bidx]  = 1'b1;
                    mBtbTag[h.bidx]    = h.tag;
                    mBtbTarget[h.bidx] = rtgt;
                end else begin
                    if (mPht[h.idx] > 0) mPht[h.idx]--;
                    if (mBtbTag[h.bidx] == h.tag) mBtbValid[h.bidx] = 1'b0;
                end
                mGhrCommit = ((mGhrCommit << 1) | int'(rt)) % (1 << GHRB);
                if (expMis) begin
                    mQ.delete();
                    mGhrSpec = ((h.ghr << 1) | int'(rt)) % (1 << GHRB);
                end
            end
            if (enq) begin
                e.idx    = idx;
                e.bidx   = bidx;
                e.tag    = tag;
                e.taken  = expTaken;
                e.target = expTarget;
                e.ghr    = mGhrSpec;
                mQ.push_back(e);
                mGhrSpec = ((mGhrSpec << 1) | int'(expTaken)) % (1 << GHRB);
            end
        end
        @(posedge clock);
    endtask

    // Fixed reset-state expectations, independent of the model.
    task automatic checkResetState();
        @(negedge clock);
        reset     = 1'b0;
        predValid = 1'b0;
        predIsBr  = 1'b1;
        predPc    = 32'h100;
        resValid  = 1'b1;
        resTaken  = 1'b1;
        resTarget = 32'h80;
        stall     = 1'b0;
        #1;
        checkOutput("rstReady",  {31'b0, predReady},     32'd1);
        checkOutput("rstTaken",  {31'b0, predTaken},     32'd0);
        checkOutput("rstTarget", predTarget,              32'h104);
        checkOutput("rstMis",    {31'b0, resMispredict}, 32'd0);
        checkOutput("rstGhr",    32'(ghrSpec),            32'd0);
        @(posedge clock);
        resValid = 1'b0;
    endtask

    initial begin
        modelReset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        checkResetState();

        // First prediction after reset: not taken, fall-through target.
        applyStimulus(0, 1, 1, 0, 32'h100, 0, 0, 32'h0);

        // Train the 0x100 branch taken to 0x80, each resolve after its enqueue.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 32'h0, 1, 1, 32'h80);
            applyStimulus(0, 1, 1, 0, 32'h100, 0, 0, 32'h0);
        end
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 1, 32'h80);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 1, 0, 32'h100, 0, 0, 32'h0);
            applyStimulus(0, 0, 0, 0, 32'h0, 1, 1, 32'h80);
        end

        // Fill the queue, try a fifth, then retire one correctly.
        for (int k = 0; k < INFLIGHT + 1; k++) applyStimulus(0, 1, 1, 0, pcPool[k], 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 1, mQ[0].taken, mQ[0].target);

        // Three queued, head resolves the other way while fetch presents a branch.
        applyStimulus(0, 1, 1, 0, 32'h2A0, 1, !mQ[0].taken, 32'h400);
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 1, 32'h80);

        // Steady state at two in flight with enqueue and correct resolve together.
        applyStimulus(0, 1, 1, 0, 32'h1F4, 0, 0, 32'h0);
        applyStimulus(0, 1, 1, 0, 32'h300, 0, 0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 1, 0, pcPool[k % 5], 1, mQ[0].taken, mQ[0].target);
        end

        // Reset in the middle with two entries still outstanding.
        applyStimulus(1, 1, 1, 0, 32'h100, 0, 0, 32'h0);
        checkResetState();

        // Randomised traffic over a small aliasing PC set.
        for (int k = 0; k < 600; k++) begin
            bit v, br, stl, rv, rt;
            logic [31:0] pc, tg;
            v   = ($urandom_range(0, 9) < 8);
            br  = ($urandom_range(0, 9) < 9);
            stl = ($urandom_range(0, 9) == 0);
            rv  = ($urandom_range(0, 9) < 4);
            rt  = ($urandom_range(0, 3) != 0);
            pc  = pcPool[$urandom_range(0, 4)];
            tg  = tgtPool[$urandom_range(0, 2)];
            if (rv && mQ.size() > 0 && $urandom_range(0, 1) == 1) tg = mQ[0].target;
            applyStimulus(($urandom_range(0, 199) == 0), v, br, stl, pc, rv, rt, tg);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
